// File: rtl/pipe_pkg.sv
// Shared encodings for the 16-bit core pipeline controller.
// Instruction classes, opcodes, bubble word and sequencer states.
package pipe_pkg;

  localparam logic [1:0] CLS_LD    = 2'b00;
  localparam logic [1:0] CLS_ST    = 2'b01;
  localparam logic [1:0] CLS_OTH   = 2'b10;
  localparam logic [1:0] CLS_ARITH = 2'b11;

  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [15:0] NOP_CMD = 16'hC0E0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  function automatic logic is_ld(input logic [15:0] c);
    return c[15:14] == CLS_LD;
  endfunction

  function automatic logic is_hlt(input logic [15:0] c);
    return (c[15:14] == CLS_ARITH) && (c[7:4] == OP_HLT);
  endfunction

  // Arith ops that read both register fields.
  function automatic logic arith_two_src(input logic [3:0] op);
    return op inside {[4'h0:OP_MOV], [4'h8:4'hB], OP_OUT};
  endfunction

endpackage

// File: rtl/src_use_decode.sv
// Source-operand usage decode for one command word.
// use_a covers [13:11], use_b covers [10:8].
module src_use_decode
  import pipe_pkg::*;
(
  input  logic [15:0] cmd,
  output logic        use_a,
  output logic        use_b,
  output logic [2:0]  src_a,
  output logic [2:0]  src_b
);

  logic [3:0] op;
  logic       unused_low;

  assign op         = cmd[7:4];
  assign src_a      = cmd[13:11];
  assign src_b      = cmd[10:8];
  assign unused_low = ^cmd[3:0];

  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    unique case (cmd[15:14])
      CLS_LD: begin
        use_b = 1'b1;
      end
      CLS_ST: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      CLS_ARITH: begin
        use_a = arith_two_src(op);
        use_b = arith_two_src(op);
      end
      CLS_OTH: begin
        use_a = 1'b0;
        use_b = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Instruction pipeline controller: ID/EX/WB command registers,
// load-use stalls, branch flushes, freeze and halt sequencing.
module pipe_sequencer #(
  parameter logic [15:0] NOP_CMD = pipe_pkg::NOP_CMD,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      imem_data,
  input  logic             branch_taken,
  output logic [15:0]      cmd_id,
  output logic [15:0]      cmd_ex,
  output logic [15:0]      cmd_wb,
  output logic             pc_en,
  output logic             stall,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_pkg::state_t state;

  logic       use_a;
  logic       use_b;
  logic [2:0] src_a;
  logic [2:0] src_b;
  logic       ld_hit;
  logic       hazard;
  logic       live;

  src_use_decode u_dec (
    .cmd   (cmd_id),
    .use_a (use_a),
    .use_b (use_b),
    .src_a (src_a),
    .src_b (src_b)
  );

  assign ld_hit = (use_a && (src_a == cmd_ex[13:11]))
               || (use_b && (src_b == cmd_ex[13:11]));
  assign hazard = pipe_pkg::is_ld(cmd_ex) && ld_hit;

  assign live   = !rst && run && (state != pipe_pkg::HALTED);
  assign flush  = live && branch_taken;
  assign stall  = live && !branch_taken && hazard;
  assign pc_en  = live
               && (branch_taken
                   || (!hazard && (state == pipe_pkg::RUN)));
  assign halted = (state == pipe_pkg::HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_id    <= NOP_CMD;
      cmd_ex    <= NOP_CMD;
      cmd_wb    <= NOP_CMD;
      stall_cnt <= '0;
      flush_cnt <= '0;
      state     <= pipe_pkg::RUN;
    end else if (run && (state != pipe_pkg::HALTED)) begin
      cmd_wb <= cmd_ex;
      if (branch_taken) begin
        // Kills ID and EX; also cancels a pending halt drain.
        cmd_id    <= NOP_CMD;
        cmd_ex    <= NOP_CMD;
        flush_cnt <= flush_cnt + CNT_W'(1);
        state     <= pipe_pkg::RUN;
      end else if (hazard) begin
        cmd_ex    <= NOP_CMD;
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        cmd_ex <= cmd_id;
        if (state == pipe_pkg::RUN) begin
          cmd_id <= imem_data;
          if (pipe_pkg::is_hlt(imem_data)) begin
            state <= pipe_pkg::DRAIN;
          end
        end else begin
          cmd_id <= NOP_CMD;
        end
        if (pipe_pkg::is_hlt(cmd_ex)) begin
          state <= pipe_pkg::HALTED;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed and random checks of pipe_sequencer against a
// behavioural pipeline model kept in the bench.
module tb_pipe_sequencer;

  localparam int          CW  = 4;
  localparam int          CM  = 1 << CW;
  localparam logic [15:0] NOP = 16'hC0E0;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          branch_taken;
  logic [15:0]   imem_data;
  logic [15:0]   cmd_id;
  logic [15:0]   cmd_ex;
  logic [15:0]   cmd_wb;
  logic          pc_en;
  logic          stall;
  logic          flush;
  logic          halted;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int n_checks;
  int n_err;

  // Model: slot 0 = ID, 1 = EX, 2 = WB; mode 0 run, 1 drain, 2 halted.
  logic [15:0] m_pipe [3];
  int          m_mode;
  int          m_sc;
  int          m_fc;

  always #5 clk = ~clk;

  pipe_sequencer #(
    .NOP_CMD (NOP),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .imem_data    (imem_data),
    .branch_taken (branch_taken),
    .cmd_id       (cmd_id),
    .cmd_ex       (cmd_ex),
    .cmd_wb       (cmd_wb),
    .pc_en        (pc_en),
    .stall        (stall),
    .flush        (flush),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_reg(input logic [15:0] c,
                                   input logic [2:0] r);
    logic [3:0] op;
    op = c[7:4];
    case (c[15:14])
      2'b00: return c[10:8] == r;
      2'b01: return (c[13:11] == r) || (c[10:8] == r);
      2'b11: begin
        if (op == 4'h7 || op == 4'hC || op >= 4'hE) return 1'b0;
        return (c[13:11] == r) || (c[10:8] == r);
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit hlt_word(input logic [15:0] c);
    return c[15:14] == 2'b11 && c[7:4] == 4'hF;
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    w = 16'($urandom);
    w[13:11] = 3'($urandom_range(0, 3));
    w[10:8]  = 3'($urandom_range(0, 3));
    if (hlt_word(w) && $urandom_range(0, 3) != 0) w[7:4] = 4'h0;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = NOP;
    m_mode = 0;
    m_sc   = 0;
    m_fc   = 0;
  endtask

  task automatic chk_regs();
    chk("cmd_id", cmd_id, m_pipe[0]);
    chk("cmd_ex", cmd_ex, m_pipe[1]);
    chk("cmd_wb", cmd_wb, m_pipe[2]);
    chk("halted", halted, m_mode == 2);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
  endtask

  // One clock: drive at negedge, check comb outputs, step, check regs.
  task automatic cyc(input logic [15:0] d, input logic bt,
                     input logic r);
    bit live;
    bit dep;
    imem_data    = d;
    branch_taken = bt;
    run          = r;
    live = r && m_mode != 2;
    dep  = m_pipe[1][15:14] == 2'b00
        && reads_reg(m_pipe[0], m_pipe[1][13:11]);
    #1;
    chk("flush", flush, live && bt);
    chk("stall", stall, live && !bt && dep);
    chk("pc_en", pc_en, live && (bt || (!dep && m_mode == 0)));
    @(posedge clk);
    if (live) begin
      m_pipe[2] = m_pipe[1];
      if (bt) begin
        m_pipe[1] = NOP;
        m_pipe[0] = NOP;
        m_fc      = (m_fc + 1) % CM;
        m_mode    = 0;
      end else if (dep) begin
        m_pipe[1] = NOP;
        m_sc      = (m_sc + 1) % CM;
      end else begin
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = (m_mode == 0) ? d : NOP;
        if (m_mode == 0 && hlt_word(d)) m_mode = 1;
        if (hlt_word(m_pipe[2])) m_mode = 2;
      end
    end
    #1;
    chk_regs();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_regs();
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_flush", flush, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_err        = 0;
    rst          = 1'b0;
    run          = 1'b1;
    branch_taken = 1'b0;
    imem_data    = NOP;
    model_reset();

    #1 rst = 1'b1;
    #1;
    chk("reset_id", cmd_id, 16'hC0E0);
    chk("reset_ex", cmd_ex, 16'hC0E0);
    chk("reset_wb", cmd_wb, 16'hC0E0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_pc_en", pc_en, 1'b0);
    chk("reset_scnt", stall_cnt, 0);
    chk("reset_fcnt", flush_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    cyc(16'h0000, 1'b0, 1'b1);
    chk("stream_id0", cmd_id, 16'h0000);
    cyc(16'hC100, 1'b0, 1'b1);
    chk("stream_ex0", cmd_ex, 16'h0000);
    cyc(16'hC200, 1'b0, 1'b1);
    cyc(NOP, 1'b0, 1'b1);
    cyc(NOP, 1'b0, 1'b1);

    do_reset();
    cyc(16'hC100, 1'b0, 1'b1);
    cyc(16'hC200, 1'b0, 1'b1);
    cyc(16'hC300, 1'b0, 1'b1);
    chk("indep_wb", cmd_wb, 16'hC100);
    chk("indep_stall", stall, 1'b0);

    do_reset();
    cyc(16'h1800, 1'b0, 1'b1);
    cyc(16'hC300, 1'b0, 1'b1);
    chk("lu_stall", stall, 1'b1);
    chk("lu_pc_en", pc_en, 1'b0);
    cyc(16'hC400, 1'b0, 1'b1);
    chk("lu_ex_bubble", cmd_ex, 16'hC0E0);
    chk("lu_id_held", cmd_id, 16'hC300);
    chk("lu_scnt", stall_cnt, 1);
    chk("lu_wb", cmd_wb, 16'h1800);

    do_reset();
    cyc(16'h8000, 1'b0, 1'b1);
    cyc(16'hC100, 1'b0, 1'b1);
    cyc(16'hC200, 1'b1, 1'b1);
    chk("br_id", cmd_id, 16'hC0E0);
    chk("br_ex", cmd_ex, 16'hC0E0);
    chk("br_wb", cmd_wb, 16'h8000);
    chk("br_fcnt", flush_cnt, 1);

    do_reset();
    cyc(16'h1800, 1'b0, 1'b1);
    cyc(16'hC300, 1'b0, 1'b1);
    cyc(16'hC400, 1'b1, 1'b1);
    chk("co_scnt", stall_cnt, 0);
    chk("co_fcnt", flush_cnt, 1);
    chk("co_id", cmd_id, 16'hC0E0);
    chk("co_wb", cmd_wb, 16'h1800);

    do_reset();
    cyc(16'hC100, 1'b0, 1'b1);
    cyc(16'hC200, 1'b0, 1'b1);
    cyc(16'hC300, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(rnd_word(), 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("frz_id", cmd_id, 16'hC300);
    chk("frz_ex", cmd_ex, 16'hC200);
    chk("frz_wb", cmd_wb, 16'hC100);
    cyc(16'hC400, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_id", cmd_id, 16'hC0E0);
    chk("async_ex", cmd_ex, 16'hC0E0);
    chk("async_wb", cmd_wb, 16'hC0E0);
    chk("async_pc_en", pc_en, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    cyc(16'hC100, 1'b0, 1'b1);
    cyc(16'hC0F0, 1'b0, 1'b1);
    chk("hlt_pc_en", pc_en, 1'b0);
    cyc(16'hC200, 1'b0, 1'b1);
    chk("hlt_id_nop", cmd_id, 16'hC0E0);
    chk("hlt_not_yet", halted, 1'b0);
    cyc(16'hC300, 1'b0, 1'b1);
    chk("hlt_wb", cmd_wb, 16'hC0F0);
    chk("hlt_halted", halted, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(rnd_word(), 1'($urandom_range(0, 1)), 1'(i % 2));
    end
    chk("hlt_hold", halted, 1'b1);
    chk("hlt_hold_wb", cmd_wb, 16'hC0F0);
    do_reset();
    chk("hlt_cleared", halted, 1'b0);

    cyc(16'h8000, 1'b0, 1'b1);
    cyc(16'hC0F0, 1'b0, 1'b1);
    cyc(16'hC100, 1'b1, 1'b1);
    chk("kill_wb", cmd_wb, 16'h8000);
    cyc(16'hC200, 1'b0, 1'b1);
    chk("kill_fetch", cmd_id, 16'hC200);
    cyc(16'hC300, 1'b0, 1'b1);
    cyc(16'hC400, 1'b0, 1'b1);
    chk("kill_running", halted, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cyc(rnd_word(), $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) != 0);
      if (m_mode == 2) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
